stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_pkg.sv | 32 +++
 rtl/stopwatch_field.sv | 84 ++++++++
 rtl/stopwatch_core.sv | 134 +++++++++++++
 tb/tb_stopwatch_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared BCD constants, digit-select encoding and clamp helper.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int DIGIT_W          = 4;
    localparam int DIGITS_PER_FIELD = 2;
    localparam int FIELD_W          = DIGIT_W * DIGITS_PER_FIELD;

    localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;

    // sel_c LSB picks the digit within a field; the upper bits pick the field.
    typedef enum logic {
        SEL_ONES = 1'b0,
        SEL_TENS = 1'b1
    } digit_pos_e;

    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] val,
        input digit_pos_e         pos
    );
        logic [DIGIT_W-1:0] lim;
        lim = (pos == SEL_TENS) ? TENS_MAX : ONES_MAX;
        return (val > lim) ? lim : val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_field.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_field
// Purpose  : One 00..59 BCD pair with step, carry/borrow chain and clamped load.
//            Down-count logic present only with STOPWATCH_CORE_DOWN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_field
    import stopwatch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               step_i,
    input  logic               dir_i,
    input  logic               load_i,
    input  digit_pos_e         load_pos_i,
    input  logic [DIGIT_W-1:0] load_val_i,
    output logic [DIGIT_W-1:0] ones_o,
    output logic [DIGIT_W-1:0] tens_o,
    output logic               carry_o
);

    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic               w_at_max;

    assign w_at_max = (ones_q == ONES_MAX) && (tens_q == TENS_MAX);

`ifdef STOPWATCH_CORE_DOWN_EN
    logic w_at_zero;
    assign w_at_zero = (ones_q == '0) && (tens_q == '0);
    assign carry_o   = step_i & (dir_i ? w_at_zero : w_at_max);
`else
    logic w_unused_dir;
    assign w_unused_dir = dir_i;
    assign carry_o      = step_i & w_at_max;
`endif

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (load_i) begin
            if (load_pos_i == SEL_TENS) begin
                tens_d = clamp_digit(load_val_i, SEL_TENS);
            end else begin
                ones_d = clamp_digit(load_val_i, SEL_ONES);
            end
        end else if (step_i) begin
`ifdef STOPWATCH_CORE_DOWN_EN
            if (dir_i) begin
                if (ones_q == '0) begin
                    ones_d = ONES_MAX;
                    tens_d = (tens_q == '0) ? TENS_MAX : tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end else
`endif
            begin
                if (ones_q == ONES_MAX) begin
                    ones_d = '0;
                    tens_d = (tens_q == TENS_MAX) ? '0 : tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones_o = ones_q;
    assign tens_o = tens_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_core
// Purpose  : Chained base-60 BCD stopwatch with pause, adjust/load and wrap flag.
//            Define STOPWATCH_CORE_DOWN_EN to enable down-count and expired_o.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int NUM_FIELDS = 2,
    parameter int SEL_W      = 3
) (
    input  logic                          clk_c,
    input  logic                          reset_c,
    input  logic                          tick_c,
    input  logic                          pause_c,
    input  logic                          adj_c,
    input  logic                          dir_c,
    input  logic                          load_c,
    input  logic [SEL_W-1:0]              sel_c,
    input  logic [DIGIT_W-1:0]            num_c,
    output logic [FIELD_W*NUM_FIELDS-1:0] digits_o,
    output logic                          paused_o,
    output logic                          wrap_o,
    output logic                          expired_o
);

    logic [1:0]            rst_sync_q;
    logic                  pause_prev_q;
    logic                  paused_q, paused_d;
    logic                  wrap_q, wrap_d;
    logic                  expired_q;
    logic                  w_ready;
    logic                  w_dir;
    logic                  w_step;
    logic                  w_sel_ok;
    logic                  w_load_acc;
    logic [SEL_W-1:0]      w_sel_field;
    logic [NUM_FIELDS-1:0] w_carry;

    // Reset assertion is asynchronous; release is staged so no step lands early.
    always_ff @(posedge clk_c or negedge reset_c) begin
        if (!reset_c) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign w_ready = rst_sync_q[1];

    assign w_sel_field = sel_c >> 1;
    assign w_sel_ok    = (32'(sel_c) < 32'(2 * NUM_FIELDS));
    assign w_load_acc  = w_ready & load_c & adj_c & w_sel_ok;
    assign w_step      = w_ready & tick_c & ~adj_c & ~paused_q
                       & ~(w_dir & expired_q) & ~w_load_acc;

    assign paused_d = paused_q ^ (pause_c & ~pause_prev_q);
    assign wrap_d   = w_step & ~w_dir & w_carry[NUM_FIELDS-1];

    always_ff @(posedge clk_c or negedge reset_c) begin
        if (!reset_c) begin
            pause_prev_q <= 1'b0;
            paused_q     <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            pause_prev_q <= pause_c;
            paused_q     <= paused_d;
            wrap_q       <= wrap_d;
        end
    end

`ifdef STOPWATCH_CORE_DOWN_EN
    localparam logic [FIELD_W*NUM_FIELDS-1:0] c_digits_one = 1;
    logic expired_d;

    assign w_dir = dir_c;

    // A down step from exactly ...00:01 is the one that lands on all zeros.
    always_comb begin
        expired_d = expired_q;
        if (w_load_acc || !dir_c) begin
            expired_d = 1'b0;
        end else if (w_step && (digits_o == c_digits_one)) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clk_c or negedge reset_c) begin
        if (!reset_c) begin
            expired_q <= 1'b0;
        end else begin
            expired_q <= expired_d;
        end
    end
`else
    logic w_unused_dir;
    assign w_unused_dir = dir_c;
    assign w_dir        = 1'b0;
    assign expired_q    = 1'b0;
`endif

    for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
        logic w_fstep;
        logic w_fload;

        if (k == 0) begin : g_lsb
            assign w_fstep = w_step;
        end else begin : g_chain
            assign w_fstep = w_carry[k-1];
        end

        assign w_fload = w_load_acc && (w_sel_field == SEL_W'(k));

        stopwatch_field u_field (
            .clk_i      (clk_c),
            .rst_ni     (reset_c),
            .step_i     (w_fstep),
            .dir_i      (w_dir),
            .load_i     (w_fload),
            .load_pos_i (digit_pos_e'(sel_c[0])),
            .load_val_i (num_c),
            .ones_o     (digits_o[FIELD_W*k +: DIGIT_W]),
            .tens_o     (digits_o[FIELD_W*k+DIGIT_W +: DIGIT_W]),
            .carry_o    (w_carry[k])
        );
    end

    assign paused_o  = paused_q;
    assign wrap_o    = wrap_q;
    assign expired_o = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_core
// Purpose  : Directed self-checking bench for stopwatch_core (2- and 3-field).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        reset_c = 1'b1;
    logic        tick_c = 1'b0;
    logic        pause_c = 1'b0;
    logic        adj_c = 1'b0;
    logic        dir_c = 1'b0;
    logic        load_c = 1'b0;
    logic [2:0]  sel_c = 3'd0;
    logic [3:0]  num_c = 4'd0;

    logic [15:0] digits2;
    logic        paused2, wrap2, expired2;
    logic [23:0] digits3;
    logic        paused3, wrap3, expired3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.NUM_FIELDS(2), .SEL_W(3)) u_dut2 (
        .clk_c     (clk),
        .reset_c   (reset_c),
        .tick_c    (tick_c),
        .pause_c   (pause_c),
        .adj_c     (adj_c),
        .dir_c     (dir_c),
        .load_c    (load_c),
        .sel_c     (sel_c),
        .num_c     (num_c),
        .digits_o  (digits2),
        .paused_o  (paused2),
        .wrap_o    (wrap2),
        .expired_o (expired2)
    );

    stopwatch_core #(.NUM_FIELDS(3), .SEL_W(3)) u_dut3 (
        .clk_c     (clk),
        .reset_c   (reset_c),
        .tick_c    (tick_c),
        .pause_c   (pause_c),
        .adj_c     (adj_c),
        .dir_c     (dir_c),
        .load_c    (load_c),
        .sel_c     (sel_c),
        .num_c     (num_c),
        .digits_o  (digits3),
        .paused_o  (paused3),
        .wrap_o    (wrap3),
        .expired_o (expired3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        tick_c = 1'b1;
        repeat (n) cyc();
        tick_c = 1'b0;
    endtask

    task automatic load_digit(input logic [2:0] sel, input logic [3:0] val);
        adj_c  = 1'b1;
        load_c = 1'b1;
        sel_c  = sel;
        num_c  = val;
        cyc();
        load_c = 1'b0;
        adj_c  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        reset_c = 1'b0;
        #1;
        total++; if (digits2 !== 16'h0000) begin bad++; $display("FAIL reset_digits: got %h expected %h", digits2, 16'h0000); end
        total++; if (paused2 !== 1'b0) begin bad++; $display("FAIL reset_paused: got %b expected 0", paused2); end
        total++; if (wrap2 !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b expected 0", wrap2); end
        total++; if (expired2 !== 1'b0) begin bad++; $display("FAIL reset_expired: got %b expected 0", expired2); end
        total++; if (digits3 !== 24'h000000) begin bad++; $display("FAIL reset_digits3: got %h expected %h", digits3, 24'h000000); end
        cyc(); cyc();
        reset_c = 1'b1;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_count_up();
        run_ticks(60);
        total++; if (digits2 !== 16'h0100) begin bad++; $display("FAIL up_60: got %h expected %h", digits2, 16'h0100); end
        run_ticks(3539);
        total++; if (digits2 !== 16'h5959) begin bad++; $display("FAIL up_3599: got %h expected %h", digits2, 16'h5959); end
        total++; if (wrap2 !== 1'b0) begin bad++; $display("FAIL up_no_wrap: got %b expected 0", wrap2); end
        run_ticks(1);
        total++; if (digits2 !== 16'h0000) begin bad++; $display("FAIL up_rollover: got %h expected %h", digits2, 16'h0000); end
        total++; if (wrap2 !== 1'b1) begin bad++; $display("FAIL up_wrap_pulse: got %b expected 1", wrap2); end
        cyc();
        total++; if (wrap2 !== 1'b0) begin bad++; $display("FAIL up_wrap_one_cycle: got %b expected 0", wrap2); end
    endtask

    task automatic test_adjust();
        load_digit(3'd1, 4'd8);
        total++; if (digits2 !== 16'h0050) begin bad++; $display("FAIL adj_tens_clamp: got %h expected %h", digits2, 16'h0050); end
        load_digit(3'd0, 4'd12);
        total++; if (digits2 !== 16'h0059) begin bad++; $display("FAIL adj_ones_clamp: got %h expected %h", digits2, 16'h0059); end
        load_digit(3'd5, 4'd3);
        total++; if (digits2 !== 16'h0059) begin bad++; $display("FAIL adj_sel_range: got %h expected %h", digits2, 16'h0059); end
        adj_c = 1'b1;
        run_ticks(3);
        adj_c = 1'b0;
        total++; if (digits2 !== 16'h0059) begin bad++; $display("FAIL adj_ticks_blocked: got %h expected %h", digits2, 16'h0059); end
        load_c = 1'b1; sel_c = 3'd2; num_c = 4'd4;
        cyc();
        load_c = 1'b0;
        total++; if (digits2 !== 16'h0059) begin bad++; $display("FAIL load_without_adj: got %h expected %h", digits2, 16'h0059); end
        run_ticks(1);
        total++; if (digits2 !== 16'h0100) begin bad++; $display("FAIL adj_exit_count: got %h expected %h", digits2, 16'h0100); end
    endtask

    task automatic test_pause();
        pause_c = 1'b1;
        tick_c  = 1'b1;
        cyc();
        tick_c  = 1'b0;
        total++; if (digits2 !== 16'h0101) begin bad++; $display("FAIL pause_edge_tick: got %h expected %h", digits2, 16'h0101); end
        total++; if (paused2 !== 1'b1) begin bad++; $display("FAIL pause_toggle_on: got %b expected 1", paused2); end
        repeat (9) cyc();
        pause_c = 1'b0;
        total++; if (paused2 !== 1'b1) begin bad++; $display("FAIL pause_held_level: got %b expected 1", paused2); end
        cyc();
        run_ticks(2);
        total++; if (digits2 !== 16'h0101) begin bad++; $display("FAIL paused_ticks: got %h expected %h", digits2, 16'h0101); end
        adj_c = 1'b1;
        repeat (3) cyc();
        adj_c = 1'b0;
        total++; if (paused2 !== 1'b1) begin bad++; $display("FAIL adj_keeps_pause: got %b expected 1", paused2); end
        pause_c = 1'b1;
        cyc();
        pause_c = 1'b0;
        total++; if (paused2 !== 1'b0) begin bad++; $display("FAIL pause_toggle_off: got %b expected 0", paused2); end
        run_ticks(1);
        total++; if (digits2 !== 16'h0102) begin bad++; $display("FAIL resume_count: got %h expected %h", digits2, 16'h0102); end
    endtask

`ifdef STOPWATCH_CORE_DOWN_EN
    task automatic test_down();
        load_digit(3'd0, 4'd0);
        load_digit(3'd1, 4'd0);
        load_digit(3'd2, 4'd1);
        load_digit(3'd3, 4'd0);
        load_digit(3'd4, 4'd1);
        load_digit(3'd5, 4'd0);
        dir_c = 1'b1;
        run_ticks(1);
        total++; if (digits2 !== 16'h0059) begin bad++; $display("FAIL down_borrow: got %h expected %h", digits2, 16'h0059); end
        total++; if (digits3 !== 24'h010059) begin bad++; $display("FAIL down_borrow3: got %h expected %h", digits3, 24'h010059); end
        dir_c = 1'b0;
        load_digit(3'd0, 4'd2);
        load_digit(3'd1, 4'd0);
        load_digit(3'd2, 4'd0);
        load_digit(3'd3, 4'd0);
        dir_c = 1'b1;
        run_ticks(1);
        total++; if (expired2 !== 1'b0) begin bad++; $display("FAIL down_not_yet_expired: got %b expected 0", expired2); end
        run_ticks(1);
        total++; if (digits2 !== 16'h0000) begin bad++; $display("FAIL down_reach_zero: got %h expected %h", digits2, 16'h0000); end
        total++; if (expired2 !== 1'b1) begin bad++; $display("FAIL down_expired: got %b expected 1", expired2); end
        run_ticks(5);
        total++; if (digits2 !== 16'h0000) begin bad++; $display("FAIL down_hold_zero: got %h expected %h", digits2, 16'h0000); end
        total++; if (expired2 !== 1'b1) begin bad++; $display("FAIL down_expired_sticky: got %b expected 1", expired2); end
        dir_c = 1'b0;
        cyc();
        total++; if (expired2 !== 1'b0) begin bad++; $display("FAIL down_expired_clear: got %b expected 0", expired2); end
    endtask
`else
    task automatic test_dir_ignored();
        load_digit(3'd0, 4'd9);
        load_digit(3'd1, 4'd5);
        load_digit(3'd2, 4'd9);
        load_digit(3'd3, 4'd5);
        load_digit(3'd4, 4'd0);
        load_digit(3'd5, 4'd0);
        dir_c = 1'b1;
        run_ticks(1);
        dir_c = 1'b0;
        total++; if (digits3 !== 24'h010000) begin bad++; $display("FAIL dir_ignored3: got %h expected %h", digits3, 24'h010000); end
        total++; if (expired3 !== 1'b0) begin bad++; $display("FAIL expired_tied3: got %b expected 0", expired3); end
        total++; if (digits2 !== 16'h0000) begin bad++; $display("FAIL dir_ignored2: got %h expected %h", digits2, 16'h0000); end
        total++; if (wrap2 !== 1'b1) begin bad++; $display("FAIL dir_ignored_wrap2: got %b expected 1", wrap2); end
        total++; if (expired2 !== 1'b0) begin bad++; $display("FAIL expired_tied2: got %b expected 0", expired2); end
    endtask
`endif

    task automatic test_reset_mid();
        load_digit(3'd0, 4'd4);
        load_digit(3'd1, 4'd3);
        load_digit(3'd2, 4'd2);
        load_digit(3'd3, 4'd1);
        total++; if (digits2 !== 16'h1234) begin bad++; $display("FAIL mid_loaded: got %h expected %h", digits2, 16'h1234); end
        tick_c = 1'b1;
        #2;
        reset_c = 1'b0;
        #1;
        total++; if (digits2 !== 16'h0000) begin bad++; $display("FAIL mid_reset_digits: got %h expected %h", digits2, 16'h0000); end
        total++; if ({paused2, wrap2, expired2} !== 3'b000) begin bad++; $display("FAIL mid_reset_flags: got %b expected 000", {paused2, wrap2, expired2}); end
        cyc();
        reset_c = 1'b1;
        cyc();
        tick_c = 1'b0;
        total++; if (digits2 !== 16'h0000) begin bad++; $display("FAIL first_edge_tick: got %h expected %h", digits2, 16'h0000); end
        cyc(); cyc();
        run_ticks(1);
        total++; if (digits2 !== 16'h0001) begin bad++; $display("FAIL post_reset_count: got %h expected %h", digits2, 16'h0001); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count_up();
        test_adjust();
        test_pause();
`ifdef STOPWATCH_CORE_DOWN_EN
        test_down();
`else
        test_dir_ignored();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
